ex_mem_stage: RTL and testbench

//  EX/MEM boundary of the 5-stage MIPS pipeline: registers execute-stage results and control,
//  fed by the ID/EX register outputs through the ALU. Runs the data-memory request handshake

---
 rtl/ex_mem_stage.sv | 137 +++++++++++++
 tb/tb_ex_mem_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX/MEM pipeline register with dcache request handshake,
//            sticky halt and saturating memory-stall cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              EN,
  input  logic              flush,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pipe_npc_i,
  input  logic [WORD_W-1:0] aluout_i,
  input  logic [WORD_W-1:0] wdat_i,
  input  logic [4:0]        wsel_i,
  input  logic [1:0]        rfInSel_i,
  input  logic              rfWEN_i,
  input  logic              dREN_i,
  input  logic              dWEN_i,
  input  logic              halt_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pipe_npc_o,
  output logic [WORD_W-1:0] aluout_o,
  output logic [4:0]        wsel_o,
  output logic [1:0]        rfInSel_o,
  output logic              rfWEN_o,
  output logic              halt_o,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic [WORD_W-1:0] dload_o,
  output logic              mem_stall_o,
  output logic [CNT_W-1:0]  wait_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] aluout;
    logic [WORD_W-1:0] store;
    logic [4:0]        wsel;
    logic [1:0]        rfInSel;
    logic              rfWEN;
    logic              dREN;
    logic              dWEN;
    logic              halt;
  } pipe_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  pipe_t             pipe_q, pipe_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall;
  logic              load;
  state_e            load_state;

  assign stall      = (state_q == S_ACCESS) && !dhit;
  assign load       = EN && !stall && !halted_q;
  assign load_state = (dREN_i || dWEN_i) ? S_ACCESS : S_IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load) state_d = load_state;
      S_ACCESS: if (dhit) state_d = load ? load_state : S_DONE;
      S_DONE:   if (load) state_d = load_state;
      default:  state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else if (load) begin
      pipe_d = '{instr: instr_i, npc: pipe_npc_i, aluout: aluout_i, store: wdat_i,
                 wsel: wsel_i, rfInSel: rfInSel_i, rfWEN: rfWEN_i, dREN: dREN_i,
                 dWEN: dWEN_i, halt: halt_i};
    end
  end

  // Halt survives flush; only reset releases a halted pipeline.
  assign halted_d = halted_q || (load && !flush && halt_i);
  assign cnt_d    = (stall && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      pipe_q   <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pipe_q   <= pipe_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  assign instr_o     = pipe_q.instr;
  assign pipe_npc_o  = pipe_q.npc;
  assign aluout_o    = pipe_q.aluout;
  assign wsel_o      = pipe_q.wsel;
  assign rfInSel_o   = pipe_q.rfInSel;
  assign rfWEN_o     = pipe_q.rfWEN;
  assign halt_o      = pipe_q.halt;
  assign dmemaddr    = pipe_q.aluout;
  assign dmemstore   = pipe_q.store;
  // A read wins when both request bits are set.
  assign dmemREN     = (state_q == S_ACCESS) && pipe_q.dREN;
  assign dmemWEN     = (state_q == S_ACCESS) && pipe_q.dWEN && !pipe_q.dREN;
  assign dload_o     = dmemload;
  assign mem_stall_o = stall;
  assign wait_cnt_o  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Random-stimulus bench for ex_mem_stage against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_stage;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          nRST, EN, flush;
  logic [W-1:0]  instr_i, pipe_npc_i, aluout_i, wdat_i, dmemload;
  logic [4:0]    wsel_i;
  logic [1:0]    rfInSel_i;
  logic          rfWEN_i, dREN_i, dWEN_i, halt_i, dhit;

  logic [W-1:0]  instr_o, pipe_npc_o, aluout_o, dmemaddr, dmemstore, dload_o;
  logic [4:0]    wsel_o;
  logic [1:0]    rfInSel_o;
  logic          rfWEN_o, halt_o, dmemREN, dmemWEN, mem_stall_o;
  logic [15:0]   wait_cnt_o;

  logic [W-1:0]  s_instr_o, s_pipe_npc_o, s_aluout_o, s_dmemaddr, s_dmemstore, s_dload_o;
  logic [4:0]    s_wsel_o;
  logic [1:0]    s_rfInSel_o;
  logic          s_rfWEN_o, s_halt_o, s_dmemREN, s_dmemWEN, s_mem_stall_o;
  logic [1:0]    s_wait_cnt_o;

  always #5 CLK = ~CLK;

  ex_mem_stage dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .flush(flush),
    .instr_i(instr_i), .pipe_npc_i(pipe_npc_i), .aluout_i(aluout_i), .wdat_i(wdat_i),
    .wsel_i(wsel_i), .rfInSel_i(rfInSel_i), .rfWEN_i(rfWEN_i), .dREN_i(dREN_i),
    .dWEN_i(dWEN_i), .halt_i(halt_i),
    .instr_o(instr_o), .pipe_npc_o(pipe_npc_o), .aluout_o(aluout_o), .wsel_o(wsel_o),
    .rfInSel_o(rfInSel_o), .rfWEN_o(rfWEN_o), .halt_o(halt_o),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .dload_o(dload_o),
    .mem_stall_o(mem_stall_o), .wait_cnt_o(wait_cnt_o)
  );

  // Narrow-counter instance shares the stimulus to exercise saturation.
  ex_mem_stage #(.CNT_W(2)) dut_s (
    .CLK(CLK), .nRST(nRST), .EN(EN), .flush(flush),
    .instr_i(instr_i), .pipe_npc_i(pipe_npc_i), .aluout_i(aluout_i), .wdat_i(wdat_i),
    .wsel_i(wsel_i), .rfInSel_i(rfInSel_i), .rfWEN_i(rfWEN_i), .dREN_i(dREN_i),
    .dWEN_i(dWEN_i), .halt_i(halt_i),
    .instr_o(s_instr_o), .pipe_npc_o(s_pipe_npc_o), .aluout_o(s_aluout_o), .wsel_o(s_wsel_o),
    .rfInSel_o(s_rfInSel_o), .rfWEN_o(s_rfWEN_o), .halt_o(s_halt_o),
    .dmemREN(s_dmemREN), .dmemWEN(s_dmemWEN), .dmemaddr(s_dmemaddr), .dmemstore(s_dmemstore),
    .dhit(dhit), .dmemload(dmemload), .dload_o(s_dload_o),
    .mem_stall_o(s_mem_stall_o), .wait_cnt_o(s_wait_cnt_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: the latched instruction plus "request outstanding" flag.
  logic [W-1:0] m_instr, m_npc, m_alu, m_store;
  logic [4:0]   m_wsel;
  logic [1:0]   m_rfsel;
  logic         m_rfwen, m_ren, m_wen, m_halt, m_halted, m_live;
  int           m_cnt, m_cnt_s;

  task automatic model_clear_regs();
    m_instr = '0; m_npc = '0; m_alu = '0; m_store = '0;
    m_wsel = '0; m_rfsel = '0; m_rfwen = 1'b0; m_ren = 1'b0; m_wen = 1'b0; m_halt = 1'b0;
    m_live = 1'b0;
  endtask

  task automatic model_step();
    bit stall;
    stall = m_live && !dhit;
    if (!nRST) begin
      model_clear_regs();
      m_halted = 1'b0;
      m_cnt    = 0;
      m_cnt_s  = 0;
    end else begin
      if (stall) begin
        m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : 65535;
        m_cnt_s = (m_cnt_s < 3)     ? m_cnt_s + 1 : 3;
      end
      if (flush) begin
        model_clear_regs();
      end else if (EN && !stall && !m_halted) begin
        m_instr = instr_i; m_npc = pipe_npc_i; m_alu = aluout_i; m_store = wdat_i;
        m_wsel = wsel_i; m_rfsel = rfInSel_i; m_rfwen = rfWEN_i;
        m_ren = dREN_i; m_wen = dWEN_i; m_halt = halt_i;
        m_live = dREN_i || dWEN_i;
        if (halt_i) m_halted = 1'b1;
      end else if (m_live && dhit) begin
        m_live = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("instr_o",    instr_o,    m_instr);
    check_val("pipe_npc_o", pipe_npc_o, m_npc);
    check_val("aluout_o",   aluout_o,   m_alu);
    check_val("dmemaddr",   dmemaddr,   m_alu);
    check_val("dmemstore",  dmemstore,  m_store);
    check_val("wsel_o",     {27'd0, wsel_o},    {27'd0, m_wsel});
    check_val("rfInSel_o",  {30'd0, rfInSel_o}, {30'd0, m_rfsel});
    check_val("rfWEN_o",    {31'd0, rfWEN_o},   {31'd0, m_rfwen});
    check_val("halt_o",     {31'd0, halt_o},    {31'd0, m_halt});
    check_val("dmemREN",    {31'd0, dmemREN},   {31'd0, m_live && m_ren});
    check_val("dmemWEN",    {31'd0, dmemWEN},   {31'd0, m_live && m_wen && !m_ren});
    check_val("mem_stall",  {31'd0, mem_stall_o}, {31'd0, m_live && !dhit});
    check_val("dload_o",    dload_o,    dmemload);
    check_val("wait_cnt",   {16'd0, wait_cnt_o},  m_cnt);
    check_val("wait_cnt_s", {30'd0, s_wait_cnt_o}, m_cnt_s);
  endtask

  initial begin
    nRST = 1'b0; EN = 1'b0; flush = 1'b0; dhit = 1'b0;
    instr_i = '0; pipe_npc_i = '0; aluout_i = '0; wdat_i = '0; dmemload = '0;
    wsel_i = '0; rfInSel_i = '0; rfWEN_i = 1'b0; dREN_i = 1'b0; dWEN_i = 1'b0; halt_i = 1'b0;
    m_halted = 1'b0;
    model_clear_regs();
    m_cnt = 0; m_cnt_s = 0;
    @(posedge CLK);
    model_step();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      nRST       = ($urandom % 70) != 0;
      flush      = ($urandom % 25) == 0;
      EN         = ($urandom % 5) != 0;
      instr_i    = $urandom;
      pipe_npc_i = $urandom;
      aluout_i   = $urandom;
      wdat_i     = $urandom;
      wsel_i     = 5'($urandom);
      rfInSel_i  = 2'($urandom);
      rfWEN_i    = 1'($urandom);
      dREN_i     = ($urandom % 3) == 0;
      dWEN_i     = ($urandom % 3) == 0;
      halt_i     = ($urandom % 60) == 0;
      dhit       = m_live && (($urandom % 4) == 0);
      dmemload   = $urandom;
      #1;
      check_outputs();
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
